// File: rtl/uart_rx_filtered.sv
// Oversampling UART receiver (8N1, LSB first) with 2-of-3 majority voting,
// glitch-start rejection, framing-error and break detection. Define UART_RX_PARITY_EN for 8E1.
module uart_rx_filtered #(
   parameter int CLK_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_serial_line,
   output logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       frame_err,
   output logic       break_det
);

   localparam int HALF = CLK_PER_BIT / 2;
   localparam logic [7:0] CNT_LAST = 8'(CLK_PER_BIT - 1);
   localparam logic [7:0] CNT_HM1  = 8'(HALF - 1);
   localparam logic [7:0] CNT_H    = 8'(HALF);
   localparam logic [7:0] CNT_HP1  = 8'(HALF + 1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      DATA       = 3'd2,
      PARITY     = 3'd3,
      STOP       = 3'd4,
      BREAK_WAIT = 3'd5
   } state_t;

   state_t     state_reg, state_next;
   logic [1:0] sync_reg;
   logic [7:0] cnt_reg, cnt_next;
   logic [2:0] idx_reg, idx_next;
   logic [7:0] shift_reg, shift_next;
   logic [1:0] samp_reg, samp_next;
   logic [7:0] data_reg, data_next;
   logic       ready_reg, ready_next;
   logic       ferr_reg, ferr_next;
   logic       brk_reg, brk_next;
   logic       s;
   logic       maj;
   logic       in_bit;

   assign s   = sync_reg[1];
   // Third vote is the live sample at the decision point (cnt == HALF+1).
   assign maj = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & s) | (samp_reg[1] & s);
   assign in_bit = (state_reg == START) || (state_reg == DATA) ||
                   (state_reg == PARITY) || (state_reg == STOP);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         sync_reg  <= 2'b11;
         cnt_reg   <= 8'd0;
         idx_reg   <= 3'd0;
         shift_reg <= 8'd0;
         samp_reg  <= 2'b00;
         data_reg  <= 8'h00;
         ready_reg <= 1'b0;
         ferr_reg  <= 1'b0;
         brk_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         sync_reg  <= {sync_reg[0], rx_serial_line};
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         shift_reg <= shift_next;
         samp_reg  <= samp_next;
         data_reg  <= data_next;
         ready_reg <= ready_next;
         ferr_reg  <= ferr_next;
         brk_reg   <= brk_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      shift_next = shift_reg;
      samp_next  = samp_reg;
      data_next  = data_reg;
      ready_next = 1'b0;
      ferr_next  = 1'b0;
      brk_next   = brk_reg;

      if (in_bit) begin
         cnt_next = cnt_reg + 8'd1;
         if (cnt_reg == CNT_HM1) samp_next[0] = s;
         if (cnt_reg == CNT_H)   samp_next[1] = s;
      end

      case (state_reg)
         IDLE: begin
            if (!s) begin
               state_next = START;
               cnt_next   = 8'd0;
            end
         end
         START: begin
            if (cnt_reg == CNT_HP1 && maj) begin
               state_next = IDLE;
               cnt_next   = 8'd0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = DATA;
               cnt_next   = 8'd0;
               idx_next   = 3'd0;
            end
         end
         DATA: begin
            if (cnt_reg == CNT_HP1) shift_next[idx_reg] = maj;
            if (cnt_reg == CNT_LAST) begin
               cnt_next = 8'd0;
               idx_next = idx_reg + 3'd1;
               if (idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_reg == CNT_HP1 && ((^shift_reg) ^ maj)) begin
               ferr_next  = 1'b1;
               state_next = IDLE;
               cnt_next   = 8'd0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = STOP;
               cnt_next   = 8'd0;
            end
         end
`endif
         STOP: begin
            if (cnt_reg == CNT_HP1) begin
               cnt_next = 8'd0;
               if (maj) begin
                  data_next  = shift_reg;
                  ready_next = 1'b1;
                  state_next = IDLE;
               end else begin
                  ferr_next = 1'b1;
                  // With parity on, reaching STOP with zero data implies a zero parity bit.
                  if (shift_reg == 8'h00) begin
                     brk_next   = 1'b1;
                     state_next = BREAK_WAIT;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
         end
         BREAK_WAIT: begin
            if (!s) begin
               cnt_next = 8'd0;
            end else if (cnt_reg == CNT_LAST) begin
               brk_next   = 1'b0;
               state_next = IDLE;
               cnt_next   = 8'd0;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 8'd0;
            brk_next   = 1'b0;
         end
      endcase
   end

   assign rx_ready  = ready_reg;
   assign rx_data   = data_reg;
   assign frame_err = ferr_reg;
   assign break_det = brk_reg;

endmodule

// File: tb/tb_uart_rx_filtered.sv
// Scoreboard bench for uart_rx_filtered: stimulus pushes expected pulses, a forked monitor pops and compares.
module tb_uart_rx_filtered;

   localparam int CPB = 16;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       line  = 1'b1;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       frame_err;
   logic       break_det;

   int checks   = 0;
   int failures = 0;
   int n_pulses = 0;

   typedef struct packed {
      logic       is_err;
      logic [7:0] data;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] last_byte = 8'h00;
`ifdef UART_RX_PARITY_EN
   logic       bad_parity = 1'b0;
`endif

   always #5 clk = ~clk;

   uart_rx_filtered #(.CLK_PER_BIT(CPB)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx_serial_line (line),
      .rx_ready       (rx_ready),
      .rx_data        (rx_data),
      .frame_err      (frame_err),
      .break_det      (break_det)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      line = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // spike_bit >= 0 inverts that data bit for one cycle at its centre.
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input int spike_bit);
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) begin
         if (i == spike_bit) begin
            hold(b[i], 8);
            hold(~b[i], 1);
            hold(b[i], CPB - 9);
         end else begin
            hold(b[i], CPB);
         end
      end
`ifdef UART_RX_PARITY_EN
      hold((^b) ^ bad_parity, CPB);
`endif
      hold(stop_v, CPB);
   endtask

   task automatic expect_byte(input logic [7:0] b);
      exp_q.push_back('{is_err: 1'b0, data: b});
      last_byte = b;
   endtask

   task automatic expect_err();
      exp_q.push_back('{is_err: 1'b1, data: last_byte});
   endtask

   initial begin
      int np;
      int n;

      fork
         begin : monitor
            exp_t e;
            forever begin
               @(negedge clk);
               if (rst_n && (rx_ready || frame_err)) begin
                  n_pulses++;
                  check("ready_ferr_exclusive", {31'd0, rx_ready & frame_err}, 32'd0);
                  if (exp_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected_pulse: rx_ready=%0b frame_err=%0b rx_data=0x%02h, required no pulse",
                              rx_ready, frame_err, rx_data);
                  end else begin
                     e = exp_q.pop_front();
                     $display("txn: %s rx_data=0x%02h", frame_err ? "frame_err" : "rx_ready ", rx_data);
                     check("sb_kind_frame_err", {31'd0, frame_err}, {31'd0, e.is_err});
                     check("sb_rx_data", {24'd0, rx_data}, {24'd0, e.data});
                  end
               end
            end
         end
      join_none

      // Reset state
      rst_n = 1'b0;
      line  = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst_rx_ready",  {31'd0, rx_ready},  32'd0);
      check("rst_rx_data",   {24'd0, rx_data},   32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_break_det", {31'd0, break_det}, 32'd0);
      rst_n = 1'b1;
      hold(1'b1, 2 * CPB);

      // Back-to-back bytes
      expect_byte(8'h55);
      send_frame(8'h55, 1'b1, -1);
      expect_byte(8'hA3);
      send_frame(8'hA3, 1'b1, -1);
      hold(1'b1, CPB);

      // Short low glitch must be rejected silently
      np = n_pulses;
      hold(1'b0, 5);
      hold(1'b1, 3 * CPB);
      check("glitch_no_pulse", n_pulses, np);
      expect_byte(8'h01);
      send_frame(8'h01, 1'b1, -1);
      hold(1'b1, CPB);

      // Bad stop bit
      expect_err();
      send_frame(8'h3C, 1'b0, -1);
      hold(1'b1, 2 * CPB);
      check("ferr_rx_data_held", {24'd0, rx_data}, 32'h01);

      // Break: 20 bit times low
      expect_err();
      hold(1'b0, 20 * CPB);
      check("break_det_high", {31'd0, break_det}, 32'd1);
      line = 1'b1;
      n = 0;
      while (break_det && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      // 2 synchroniser cycles plus 16 high cycles; allow the sync skew as tolerance
      checks++;
      if (n < 16 || n > 18) begin
         failures++;
         $display("FAIL break_release: break_det fell after %0d cycles, required 16..18", n);
      end
      hold(1'b1, 2 * CPB);
      expect_byte(8'hFF);
      send_frame(8'hFF, 1'b1, -1);
      hold(1'b1, CPB);

      // Single-cycle spikes at bit centres are outvoted
      expect_byte(8'h0F);
      send_frame(8'h0F, 1'b1, 2);
      expect_byte(8'h0F);
      send_frame(8'h0F, 1'b1, 6);
      hold(1'b1, CPB);

      // Reset during bit 4 of 8'h81
      hold(1'b0, CPB);
      hold(1'b1, CPB);
      hold(1'b0, CPB);
      hold(1'b0, CPB);
      hold(1'b0, CPB);
      hold(1'b0, 5);
      rst_n = 1'b0;
      line  = 1'b1;
      @(posedge clk);
      #1;
      last_byte = 8'h00;
      check("midrst_rx_ready",  {31'd0, rx_ready},  32'd0);
      check("midrst_rx_data",   {24'd0, rx_data},   32'd0);
      check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
      check("midrst_break_det", {31'd0, break_det}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      hold(1'b1, 2 * CPB);
      check("midrst_no_byte", {24'd0, rx_data}, 32'd0);
      expect_byte(8'h42);
      send_frame(8'h42, 1'b1, -1);
      hold(1'b1, CPB);

`ifdef UART_RX_PARITY_EN
      // Wrong parity bit
      bad_parity = 1'b1;
      expect_err();
      send_frame(8'h07, 1'b1, -1);
      bad_parity = 1'b0;
      hold(1'b1, 2 * CPB);
      check("parity_rx_data_held", {24'd0, rx_data}, 32'h42);
`endif

      // Every expected pulse must have appeared
      n = 0;
      while (exp_q.size() != 0 && n < 4 * CPB) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("sb_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
